// File: rtl/des_pkg.sv
// des_pkg: shared DES round definitions.
//   - DES_HALF_W / DES_KEY_W: half-block and round-subkey widths.
//   - DES_E_TABLE:    expansion E, 48 source bit numbers (DES numbering, bit 1 = MSB).
//   - DES_P_TABLE:    permutation P, 32 source bit numbers (DES numbering).
//   - DES_SBOX_TABLE: S1..S8 contents. There are 64 nibbles per box, in row-major order.
//                     Entry 0 is the most significant nibble.
//   - des_expand / des_permute_p: table-driven bit shuffles used by the round.
package des_pkg;

  localparam int DES_HALF_W = 32;
  localparam int DES_KEY_W  = 48;

  localparam int DES_E_TABLE [0:47] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int DES_P_TABLE [0:31] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each row of a box is 16 nibbles; rows 0..3 appear left to right.
  localparam logic [255:0] DES_SBOX_TABLE [0:7] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Expansion E: output bit i (DES numbering) takes input bit DES_E_TABLE[i].
  function automatic logic [DES_KEY_W-1:0] des_expand(input logic [DES_HALF_W-1:0] r);
    logic [DES_KEY_W-1:0] x;
    x = 48'd0;
    for (int i = 0; i < 48; i++) begin
      x[6'(47 - i)] = r[5'(32 - DES_E_TABLE[i])];
    end
    return x;
  endfunction

  // Permutation P: output bit i (DES numbering) takes input bit DES_P_TABLE[i].
  function automatic logic [DES_HALF_W-1:0] des_permute_p(input logic [DES_HALF_W-1:0] s);
    logic [DES_HALF_W-1:0] p;
    p = 32'd0;
    for (int i = 0; i < 32; i++) begin
      p[5'(31 - i)] = s[5'(32 - DES_P_TABLE[i])];
    end
    return p;
  endfunction

endpackage

// File: rtl/des_sbox_layer.sv
// des_sbox: a single DES S-box (S1..S8 selected by SBOX_IDX 0..7), purely combinational.
//   DataIn  [5:0] raw 6-bit group, DES bit 1 = MSB (row = {b5,b0}, column = b4..b1).
//   DataOut [3:0] box output.
// des_sbox_layer: all eight S-boxes side by side, purely combinational.
//   DataIn  [47:0] expanded-and-keyed half block; [47:42] feeds S1 ... [5:0] feeds S8.
//   DataOut [31:0] S1..S8 outputs concatenated, S1 in the top nibble (before P).
module des_sbox
  import des_pkg::*;
#(
  parameter int SBOX_IDX = 0
) (
  input  logic [5:0] DataIn,
  output logic [3:0] DataOut
);

  localparam logic [255:0] TABLE_C = DES_SBOX_TABLE[SBOX_IDX];

  logic [5:0] entryIdx_s;
  logic [7:0] bitPos_s;

  // Outer bits pick the row and inner bits the column; entry 0 sits at the table MSB.
  always_comb begin
    entryIdx_s = {DataIn[5], DataIn[0], DataIn[4:1]};
    bitPos_s   = 8'd255 - {entryIdx_s, 2'b00};
    DataOut    = TABLE_C[bitPos_s -: 4];
  end

endmodule

module des_sbox_layer
  import des_pkg::*;
(
  input  logic [DES_KEY_W-1:0]  DataIn,
  output logic [DES_HALF_W-1:0] DataOut
);

  for (genvar g = 0; g < 8; g++) begin : gSbox
    des_sbox #(
      .SBOX_IDX (g)
    ) uSbox (
      .DataIn  (DataIn[47-6*g -: 6]),
      .DataOut (DataOut[31-4*g -: 4])
    );
  end

endmodule

// File: rtl/des_round_pipe.sv
// des_round_pipe: two-stage elastic DES Feistel round.
//   Stage 1 registers X = E(R) ^ K together with L and R.
//   Stage 2 runs S1..S8 and P on X and registers the next-round halves.
// Ports:
//   Clk, RstN           rising-edge clock, asynchronous active-low reset
//   InValid / InReady   input handshake; InL, InR [31:0], InKey [47:0] (bit 1 = MSB)
//   InLast              final-round flag; present only with DES_ROUND_FINAL_SWAP_EN
//   OutValid / OutReady output handshake; OutL, OutR [31:0] next-round halves
// Build option DES_ROUND_FINAL_SWAP_EN:
//   When it is defined, a round tagged InLast=1 skips the half swap (round 16).
module des_round_pipe
  import des_pkg::*;
(
  input  logic                  Clk,
  input  logic                  RstN,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DES_HALF_W-1:0] InL,
  input  logic [DES_HALF_W-1:0] InR,
  input  logic [DES_KEY_W-1:0]  InKey,
`ifdef DES_ROUND_FINAL_SWAP_EN
  input  logic                  InLast,
`endif
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DES_HALF_W-1:0] OutL,
  output logic [DES_HALF_W-1:0] OutR
);

  logic                  s1Valid_r;
  logic [DES_HALF_W-1:0] s1L_r;
  logic [DES_HALF_W-1:0] s1R_r;
  logic [DES_KEY_W-1:0]  s1X_r;
`ifdef DES_ROUND_FINAL_SWAP_EN
  logic                  s1Last_r;
`endif
  logic                  s2Valid_r;

  logic                  s2Adv_s;
  logic                  s1Adv_s;
  logic                  s1Load_s;
  logic                  s2Load_s;
  logic [DES_HALF_W-1:0] sboxOut_s;
  logic [DES_HALF_W-1:0] f_s;
  logic [DES_HALF_W-1:0] nextL_s;
  logic [DES_HALF_W-1:0] nextR_s;

  // Handshake control.
  // A stage may load when it is empty or its contents leave in the same cycle.
  always_comb begin
    s2Adv_s  = !s2Valid_r || OutReady;
    s1Adv_s  = !s1Valid_r || s2Adv_s;
    s1Load_s = InValid && s1Adv_s;
    s2Load_s = s1Valid_r && s2Adv_s;
    InReady  = s1Adv_s;
    OutValid = s2Valid_r;
  end

  des_sbox_layer uSboxLayer (
    .DataIn  (s1X_r),
    .DataOut (sboxOut_s)
  );

  // Round function output and next halves; the last round keeps L^f on the left.
  always_comb begin
    f_s     = des_permute_p(sboxOut_s);
    nextL_s = s1R_r;
    nextR_s = s1L_r ^ f_s;
`ifdef DES_ROUND_FINAL_SWAP_EN
    if (s1Last_r) begin
      nextL_s = s1L_r ^ f_s;
      nextR_s = s1R_r;
    end else begin
      nextL_s = s1R_r;
      nextR_s = s1L_r ^ f_s;
    end
`endif
  end

  // Pipeline registers.
  // Valids follow the handshake, and data registers load only when their stage takes a new item.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      s1Valid_r <= 1'b0;
      s1L_r     <= 32'd0;
      s1R_r     <= 32'd0;
      s1X_r     <= 48'd0;
`ifdef DES_ROUND_FINAL_SWAP_EN
      s1Last_r  <= 1'b0;
`endif
      s2Valid_r <= 1'b0;
      OutL      <= 32'd0;
      OutR      <= 32'd0;
    end else begin
      if (s1Adv_s) begin
        s1Valid_r <= InValid;
      end
      if (s1Load_s) begin
        s1L_r    <= InL;
        s1R_r    <= InR;
        s1X_r    <= des_expand(InR) ^ InKey;
`ifdef DES_ROUND_FINAL_SWAP_EN
        s1Last_r <= InLast;
`endif
      end
      if (s2Adv_s) begin
        s2Valid_r <= s1Valid_r;
      end
      if (s2Load_s) begin
        OutL <= nextL_s;
        OutR <= nextR_s;
      end
    end
  end

endmodule
